serial_add_ctrl: RTL and testbench

- Bit-serial add/subtract sequencer. It time-shares a single full_adder cell across WIDTH clock cycles, so one 1-bit datapath produces a WIDTH-bit sum.
- Operands and control come from the board switches and buttons. Result, carry and status drive the LEDs.
- Replaces the chained full_adder ripple structure when operand width grows beyond a few bits.
- Uses a start/busy/done handshake so the top level or a display block knows when the result is valid.

---
 rtl/serial_add_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer.
// A single full_adder cell is reused for WIDTH cycles to build a WIDTH-bit
// sum, carry out and signed overflow. start/busy/done handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one operand bit per cycle through the adder cell, LSB first
// DONE  | result registers load, done pulses, back to IDLE

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  // Plain 1-bit full adder; the only adder in the sequencer.
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             cy;
  logic             cmsb;
  logic             fa_s;
  logic             fa_c;

  // Operand LSBs and the running carry feed the shared adder cell.
  full_adder u_fa (
    .x  (sa[0]),
    .y  (sb[0]),
    .ci (cy),
    .s  (fa_s),
    .co (fa_c)
  );

  // Sequencer: capture, shift one bit per RUN cycle, publish in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      cnt      <= '0;
      cy       <= 1'b0;
      cmsb     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            // Subtraction is A + ~B + 1, so c_in is not used in sub mode.
            sb    <= sub ? ~b : b;
            cy    <= sub | c_in;
            cnt   <= '0;
            sr    <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sr <= {fa_s, sr[WIDTH-1:1]};
          sa <= sa >> 1;
          sb <= sb >> 1;
          cy <= fa_c;
          if (cnt == CNT_LAST) begin
            // Carry into the MSB cell, needed for signed overflow.
            cmsb  <= cy;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          sum      <= sr;
          c_out    <= cy;
          overflow <= cmsb ^ cy;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed vectors,
// handshake timing, busy lockout, reset abort, back-to-back and random ops
// against an integer-arithmetic reference model.

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  int total;
  int bad;

  serial_add_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {overflow, c_out, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic ci, input logic sb);
    int ua, ub, sa_i, sb_i, r, sres;
    logic co, ov;
    logic [W-1:0] s;
    ua   = av;
    ub   = bv;
    sa_i = $signed(av);
    sb_i = $signed(bv);
    if (sb) begin
      r    = ua - ub;
      co   = (ua >= ub);
      sres = sa_i - sb_i;
    end else begin
      r    = ua + ub + int'(ci);
      co   = (r > 255);
      sres = sa_i + sb_i + int'(ci);
    end
    s  = r[W-1:0];
    ov = (sres > 127) || (sres < -128);
    return {ov, co, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start pulse, then follow the op until done or a cycle budget.
  // lat: sample index (1 = cycle after the accepting edge) where done is seen.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb,
                        output int lat, output int busy_cnt, output bit got);
    a = av; b = bv; c_in = ci; sub = sb; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; busy_cnt = 0; got = 1'b0;
    for (int i = 1; i <= 30 && !got; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
        lat = i;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", sum); end
    total++; if (c_out !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", c_out); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{8'h2D, 8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [W-1:0] tb [5] = '{8'h1B, 8'h01, 8'h00, 8'h07, 8'h01};
    logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] es [5] = '{8'h48, 8'h00, 8'h80, 8'hFE, 8'h7F};
    logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int lat, bc;
    bit got;
    for (int k = 0; k < 5; k++) begin
      run_op(ta[k], tb[k], tc[k], ts[k], lat, bc, got);
      total++;
      if (!got) begin
        bad++; $display("FAIL dir%0d_timeout got=no_done want=done", k);
      end else begin
        total++; if (sum !== es[k]) begin bad++; $display("FAIL dir%0d_sum got=%h want=%h", k, sum, es[k]); end
        total++; if (c_out !== ec[k]) begin bad++; $display("FAIL dir%0d_cout got=%b want=%b", k, c_out, ec[k]); end
        total++; if (overflow !== eo[k]) begin bad++; $display("FAIL dir%0d_ovf got=%b want=%b", k, overflow, eo[k]); end
        total++; if (lat != W + 2) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, lat, W + 2); end
        total++; if (bc != W + 1) begin bad++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", k, bc, W + 1); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL dir%0d_done_width got=%b want=0", k, done); end
        total++; if (sum !== es[k]) begin bad++; $display("FAIL dir%0d_sum_hold got=%h want=%h", k, sum, es[k]); end
      end
    end
  endtask

  // Result outputs must keep the previous value while a new op runs.
  task automatic test_result_hold();
    logic [W-1:0] prev;
    prev = sum;
    a = 8'h11; b = 8'h22; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      total++; if (sum !== prev) begin bad++; $display("FAIL hold_sum cyc%0d got=%h want=%h", i, sum, prev); end
      tick();
    end
    for (int i = 0; i < 5; i++) tick();
    total++; if (sum !== 8'h33) begin bad++; $display("FAIL hold_final_sum got=%h want=33", sum); end
  endtask

  task automatic test_busy_lockout();
    int ndone;
    a = 8'h10; b = 8'h20; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 3) begin
        a = 8'h44; b = 8'h55; sub = 1'b1; c_in = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        total++; if (sum !== 8'h30) begin bad++; $display("FAIL lockout_sum got=%h want=30", sum); end
      end
      tick();
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL lockout_done_count got=%0d want=1", ndone); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lockout_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int ndone, lat, bc;
    bit got;
    a = 8'hAA; b = 8'h55; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL midrst_sum got=%h want=00", sum); end
    total++; if (c_out !== 1'b0) begin bad++; $display("FAIL midrst_cout got=%b want=0", c_out); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b want=0", overflow); end
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) ndone++;
      tick();
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL midrst_stray_done got=%0d want=0", ndone); end
    run_op(8'h01, 8'h02, 1'b0, 1'b0, lat, bc, got);
    total++;
    if (!got) begin bad++; $display("FAIL midrst_timeout got=no_done want=done"); end
    else if (sum !== 8'h03) begin bad++; $display("FAIL midrst_after_sum got=%h want=03", sum); end
    tick();
  endtask

  task automatic test_back_to_back();
    int didx [$];
    logic busy_hist [25];
    int lows;
    a = 8'h03; b = 8'h04; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      busy_hist[i] = busy;
      if (done) begin
        didx.push_back(i);
        total++; if (sum !== 8'h07) begin bad++; $display("FAIL b2b_sum idx%0d got=%h want=07", i, sum); end
      end
    end
    start = 1'b0;
    total++; if (didx.size() < 2) begin bad++; $display("FAIL b2b_done_count got=%0d want>=2", didx.size()); end
    for (int k = 1; k < didx.size(); k++) begin
      total++;
      if (didx[k] - didx[k-1] != W + 2) begin
        bad++; $display("FAIL b2b_spacing got=%0d want=%0d", didx[k] - didx[k-1], W + 2);
      end
      lows = 0;
      for (int j = didx[k-1]; j < didx[k]; j++) if (!busy_hist[j]) lows++;
      total++; if (lows != 1) begin bad++; $display("FAIL b2b_busy_low got=%0d want=1", lows); end
    end
    for (int i = 0; i < 15; i++) tick();
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic rc, rs;
    logic [W+1:0] exp;
    int lat, bc;
    bit got;
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      exp = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, lat, bc, got);
      total++;
      if (!got) begin
        bad++; $display("FAIL rand%0d_timeout got=no_done want=done", n);
      end else if ({overflow, c_out, sum} !== exp) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h cin=%b sub=%b got=ovf%b/co%b/%h want=ovf%b/co%b/%h",
                 n, ra, rb, rc, rs, overflow, c_out, sum, exp[W+1], exp[W], exp[W-1:0]);
      end
      // Scramble inputs after acceptance; they must not matter.
      a = W'($urandom); b = W'($urandom);
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_result_hold();
    test_busy_lockout();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
